// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the tenths-of-a-second stopwatch.
// The BCD increment helper is used by the count cascade in the top level.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } state_t;

  localparam logic [3:0] TENTH_MAX = 4'd9;
  localparam logic [3:0] SEC_O_MAX = 4'd9;
  localparam logic [2:0] SEC_T_MAX = 3'd5;
  localparam logic [3:0] MIN_O_MAX = 4'd9;
  localparam logic [2:0] MIN_T_MAX = 3'd5;

  typedef struct packed {
    logic [2:0] min_t;
    logic [3:0] min_o;
    logic [2:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] tenth;
  } bcd_time_t;

  function automatic logic bcd_full(input bcd_time_t t);
    return (t.tenth == TENTH_MAX) && (t.sec_o == SEC_O_MAX) &&
           (t.sec_t == SEC_T_MAX) && (t.min_o == MIN_O_MAX) &&
           (t.min_t == MIN_T_MAX);
  endfunction

  // Ripple carry through the digits; 59:59.9 wraps to zero.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.tenth != TENTH_MAX) begin
      r.tenth = t.tenth + 4'd1;
    end else begin
      r.tenth = '0;
      if (t.sec_o != SEC_O_MAX) begin
        r.sec_o = t.sec_o + 4'd1;
      end else begin
        r.sec_o = '0;
        if (t.sec_t != SEC_T_MAX) begin
          r.sec_t = t.sec_t + 3'd1;
        end else begin
          r.sec_t = '0;
          if (t.min_o != MIN_O_MAX) begin
            r.min_o = t.min_o + 4'd1;
          end else begin
            r.min_o = '0;
            if (t.min_t != MIN_T_MAX) r.min_t = t.min_t + 3'd1;
            else                      r.min_t = '0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_btn_event.sv
// Button conditioner: multi-flop synchronizer followed by a
// rising-edge detector producing a single-cycle event.
module btn_event #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic ev
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign ev = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch top: button events, run/stop/lap FSM, BCD count cascade
// and the lap-freezable display registers.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic [2:0] min_t,
  output logic [3:0] min_o,
  output logic [2:0] sec_t,
  output logic [3:0] sec_o,
  output logic [3:0] tenth,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);

  logic      ev_ss;
  logic      ev_lr;
  state_t    state;
  state_t    state_nxt;
  bcd_time_t cnt;
  bcd_time_t cnt_nxt;
  bcd_time_t disp;
  logic      ovf_nxt;

  btn_event #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_ss),
    .ev    (ev_ss)
  );

  btn_event #(.SYNC_STAGES(SYNC_STAGES)) u_lr (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lr),
    .ev    (ev_lr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      overflow <= ovf_nxt;
      // Freeze only while both this and the next cycle are LAP.
      if (!(state == LAP && state_nxt == LAP)) disp <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = overflow;
    if (tick && (state == RUN || state == LAP)) begin
      cnt_nxt = bcd_inc(cnt);
      if (bcd_full(cnt)) ovf_nxt = 1'b1;
    end
    unique case (state)
      IDLE: if (ev_ss) state_nxt = RUN;
      RUN: begin
        if (ev_ss)      state_nxt = STOP;
        else if (ev_lr) state_nxt = LAP;
      end
      LAP: begin
        if (ev_ss)      state_nxt = STOP;
        else if (ev_lr) state_nxt = RUN;
      end
      STOP: begin
        if (ev_ss) begin
          state_nxt = RUN;
        end else if (ev_lr) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign min_t      = disp.min_t;
  assign min_o      = disp.min_o;
  assign sec_t      = disp.sec_t;
  assign sec_o      = disp.sec_o;
  assign tenth      = disp.tenth;
  assign running    = (state == RUN) || (state == LAP);
  assign lap_active = (state == LAP);

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Consumer end of the 10 Hz enable tick: a tenths-of-a-second stopwatch that counts one-cycle `tick` pulses while running and presents the time as BCD digits. It converts two asynchronous push-buttons into clean one-cycle events and provides start/stop, lap-freeze and clear control. It sits between the sub-second tick divider and the display driver.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops per button input. Legal values are 2 or more.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset; clock `clk`.
- `tick`  in  1  10 Hz enable, high for exactly one `clk` cycle, synchronous to `clk`.
- `btn_ss`  in  1  start/stop button; raw asynchronous level, active-high.
- `btn_lr`  in  1  lap/clear button; raw asynchronous level, active-high.
- `min_t`  out  3  minutes tens digit, BCD 0–5.
- `min_o`  out  4  minutes ones digit, BCD 0–9.
- `sec_t`  out  3  seconds tens digit, BCD 0–5.
- `sec_o`  out  4  seconds ones digit, BCD 0–9.
- `tenth`  out  4  tenths digit, BCD 0–9.
- `running`  out  1  high in states RUN and LAP.
- `lap_active`  out  1  high in state LAP (display frozen).
- `overflow`  out  1  sticky flag; the count wrapped past 59:59.9.

## Operation
- **Button events.** Each button passes through a `SYNC_STAGES`-flop synchronizer and then a rising-edge detector. The result is a one-cycle event: `ev_ss` or `ev_lr`. Holding a button produces exactly one event.
- **States.** IDLE, RUN, STOP, LAP.
- **Transitions.**
  - IDLE: `ev_ss` goes to RUN. `ev_lr` is ignored.
  - RUN: `ev_ss` goes to STOP. `ev_lr` goes to LAP.
  - LAP: `ev_ss` goes to STOP, and the display returns to live. `ev_lr` goes to RUN.
  - STOP: `ev_ss` goes to RUN. `ev_lr` goes to IDLE, clears the count to 00:00.0 and clears `overflow`.
- **Simultaneous events.** `ev_ss` has priority; `ev_lr` in the same cycle is discarded.
- **Counting.**
  - The count increments on `tick` when the current state is RUN or LAP. The state is taken before the transition of that same cycle.
  - A tick in IDLE or STOP is ignored.
  - The digits form a BCD cascade: `tenth` 9→0 carries into `sec_o`; `sec_o` 9→0 carries into `sec_t`; `sec_t` 5→0 carries into `min_o`; `min_o` 9→0 carries into `min_t`.
  - At 59:59.9, a tick produces 00:00.0 and sets `overflow`. Counting continues.
- **Display.**
  - The digit outputs are registers.
  - When the next state is not LAP, or when the current state is not LAP, they load the next count value. The display therefore equals the count register with no lag, including on the lap-entry edge.
  - While the design stays in LAP, the digits hold the snapshot.
- **Reset mid-operation.** All state is cleared immediately and asynchronously: state IDLE, count 0, every output 0, synchronizer and edge flops 0. An event in flight when reset asserts is lost.

## Timing
- **Reset values.** All outputs are 0, state is IDLE, `overflow` is 0.
- **Button latency.** The effect of a button press is visible `SYNC_STAGES`+1 rising edges after the first edge that samples the button high. With the default, that is 3 edges.
- **Tick latency.** A tick sampled at edge N updates the digits at edge N. The new value is visible in the cycle after N.
- **Back-to-back ticks.** Consecutive-cycle ticks are not produced upstream. If they occur, each one still increments.

## Structure
- **Package `stopwatch_pkg`:**
  - state enum (IDLE, RUN, STOP, LAP);
  - digit limits TENTH_MAX=9, SEC_O_MAX=9, SEC_T_MAX=5, MIN_O_MAX=9, MIN_T_MAX=5.
- **Sub-module `btn_event`:** synchronizer plus rising-edge detector, parameterized by `SYNC_STAGES`. It is instantiated twice.
- **Top level:** the FSM, the BCD cascade and the display registers stay in `stopwatch_bcd`.

## Test plan
- **Basic count.** Reset, press `btn_ss`, apply 10 ticks. Expect 00:01.0 and `running`=1. Then 590 more ticks: expect 01:00.0.
- **Ignored ticks and latency.** Apply 5 ticks in IDLE: display stays 00:00.0. With `SYNC_STAGES`=2, `running` rises exactly 3 edges after `btn_ss` is first sampled high. Holding the button for 1000 cycles gives exactly one event.
- **Lap.** At 00:12.3 press `btn_lr`. Expect `lap_active`=1 and the display frozen at 00:12.3 for 20 ticks. Then press `btn_lr`: display shows 00:14.3 and `lap_active`=0.
- **Stop and clear.** Press `btn_ss` in RUN: count holds through 7 ticks. Press `btn_lr` in STOP: 00:00.0, IDLE, `overflow`=0.
- **Overflow and boundary.**
  - Run 35999 ticks: expect 59:59.9 with `overflow`=0.
  - One more tick: expect 00:00.0 with `overflow`=1.
  - A tick in the same cycle as `ev_ss` in RUN: it is counted and the state goes to STOP.
  - Both events in the same cycle in RUN: state goes to STOP, not LAP.
- **Asynchronous reset.** Assert `reset` mid-count at 03:21.4, between clock edges. All outputs go to 0 immediately. After release, the design is in IDLE and ignores ticks.
